// File: rtl/bnn_classifier_seq.sv
// bnn_classifier_seq: time-multiplexed binary neural network classifier with serial weight loading
module bnn_classifier_seq #(
    parameter int N_IN   = 8,
    parameter int N_HID  = 8,
    parameter int N_OUT  = 4,
    parameter int FEAT_W = 4,
    parameter int BIAS_W = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_IN*FEAT_W-1:0]       feat_in,
    input  logic                         start,
    input  logic                         w_load,
    input  logic                         w_bit,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(N_OUT)-1:0]     class_idx,
    output logic [$clog2(N_HID+1)-1:0]   class_score,
    output logic [N_HID-1:0]             hidden_act
);
    localparam int WBITS   = N_HID*N_IN + N_OUT*N_HID + N_HID*BIAS_W;
    localparam int HO_BASE = N_HID*N_IN;
    localparam int B_BASE  = HO_BASE + N_OUT*N_HID;
    localparam int CW      = $clog2(N_IN+1);
    localparam int SW      = CW + BIAS_W + 1;
    localparam int SCW     = $clog2(N_HID+1);
    localparam int CIW     = $clog2(N_OUT);
    localparam int IW      = $clog2(N_HID > N_OUT ? N_HID : N_OUT);

    typedef enum logic [1:0] {IDLE, HID, OUT, DONE} state_t;

    state_t                  state, state_nx;
    logic [WBITS-1:0]        wreg;
    logic [N_IN-1:0]         x, x_bin, eq_ih;
    logic [N_HID-1:0]        eq_ho;
    logic [IW-1:0]           idx;
    logic [CW-1:0]           match;
    logic signed [SW-1:0]    s;
    logic [SCW-1:0]          score, max_score, win_score;
    logic [CIW-1:0]          max_idx, win_idx;
    logic                    last_hid, last_out, take;

    assign busy     = state != IDLE;
    assign done     = state == DONE;
    assign last_hid = idx == IW'(N_HID-1);
    assign last_out = idx == IW'(N_OUT-1);

    // Binarize features: a feature is 1 when it is in the upper half of its range
    always_comb begin
        for (int i = 0; i < N_IN; i++)
            x_bin[i] = feat_in[i*FEAT_W +: FEAT_W] >= FEAT_W'(1 << (FEAT_W-1));
    end

    // Neuron evaluation for the current index: hidden pre-activation and class score with running-max compare
    always_comb begin
        eq_ih = ~(x ^ wreg[32'(idx)*N_IN +: N_IN]);
        eq_ho = ~(hidden_act ^ wreg[HO_BASE + 32'(idx)*N_HID +: N_HID]);
        match = '0;
        for (int i = 0; i < N_IN; i++)
            match = match + CW'(eq_ih[i]);
        score = '0;
        for (int j = 0; j < N_HID; j++)
            score = score + SCW'(eq_ho[j]);
        s = $signed(SW'(match)) + SW'($signed(wreg[B_BASE + 32'(idx)*BIAS_W +: BIAS_W])) - SW'(N_IN/2);
        take = score > max_score;
        win_idx = take ? CIW'(idx) : max_idx;
        win_score = take ? score : max_score;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: state_nx = start ? HID : IDLE;
            HID:  state_nx = last_hid ? OUT : HID;
            OUT:  state_nx = last_out ? DONE : OUT;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: weight chain, feature latch, hidden layer, running argmax and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wreg        <= '0;
            x           <= '0;
            idx         <= '0;
            hidden_act  <= '0;
            max_score   <= '0;
            max_idx     <= '0;
            class_idx   <= '0;
            class_score <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        x         <= x_bin;
                        idx       <= '0;
                        max_score <= '0;
                        max_idx   <= '0;
                    end else if (w_load) begin
                        wreg <= {wreg[WBITS-2:0], w_bit};
                    end
                end
                HID: begin
                    hidden_act[idx] <= ~s[SW-1];
                    idx             <= last_hid ? '0 : idx + IW'(1);
                end
                OUT: begin
                    max_score <= win_score;
                    max_idx   <= win_idx;
                    idx       <= idx + IW'(1);
                    if (last_out) begin
                        class_idx   <= win_idx;
                        class_score <= win_score;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bnn_classifier_seq.sv
// tb_bnn_classifier_seq: randomized self-checking bench against an array-based BNN reference model
module tb_bnn_classifier_seq;
    localparam int N_IN   = 8;
    localparam int N_HID  = 8;
    localparam int N_OUT  = 4;
    localparam int FEAT_W = 4;
    localparam int BIAS_W = 4;
    localparam int WBITS  = N_HID*N_IN + N_OUT*N_HID + N_HID*BIAS_W;
    localparam int FW     = N_IN*FEAT_W;
    localparam int LAT    = N_HID + N_OUT + 1;

    logic                         clk = 1'b0;
    logic                         rst, start, w_load, w_bit;
    logic [FW-1:0]                feat_in;
    logic                         busy, done;
    logic [$clog2(N_OUT)-1:0]     class_idx;
    logic [$clog2(N_HID+1)-1:0]   class_score;
    logic [N_HID-1:0]             hidden_act;

    int checks = 0;
    int errors = 0;

    logic w_ih [N_HID][N_IN];
    logic w_ho [N_OUT][N_HID];
    int   bias [N_HID];

    always #5 clk = ~clk;

    bnn_classifier_seq dut (
        .clk(clk), .rst(rst), .feat_in(feat_in), .start(start), .w_load(w_load), .w_bit(w_bit),
        .busy(busy), .done(done), .class_idx(class_idx), .class_score(class_score), .hidden_act(hidden_act)
    );

    // Compare one observed value with its expected value
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void clear_weights();
        for (int j = 0; j < N_HID; j++) begin
            bias[j] = 0;
            for (int i = 0; i < N_IN; i++) w_ih[j][i] = 1'b0;
            for (int k = 0; k < N_OUT; k++) w_ho[k][j] = 1'b0;
        end
    endfunction

    function automatic void random_weights();
        for (int j = 0; j < N_HID; j++) begin
            bias[j] = int'($urandom_range(0, 15)) - 8;
            for (int i = 0; i < N_IN; i++) w_ih[j][i] = 1'($urandom);
            for (int k = 0; k < N_OUT; k++) w_ho[k][j] = 1'($urandom);
        end
    endfunction

    function automatic logic [WBITS-1:0] pack();
        logic [WBITS-1:0]  v = '0;
        logic [BIAS_W-1:0] b;
        for (int j = 0; j < N_HID; j++) begin
            for (int i = 0; i < N_IN; i++) v[j*N_IN + i] = w_ih[j][i];
            for (int k = 0; k < N_OUT; k++) v[N_HID*N_IN + k*N_HID + j] = w_ho[k][j];
            b = BIAS_W'(bias[j]);
            for (int t = 0; t < BIAS_W; t++) v[N_HID*N_IN + N_OUT*N_HID + j*BIAS_W + t] = b[t];
        end
        return v;
    endfunction

    // Reference: integer arithmetic straight from the network definition
    function automatic void model(input logic [FW-1:0] f, output logic [N_HID-1:0] h, output int ci, output int cs);
        int cnt, sc;
        logic xi;
        for (int j = 0; j < N_HID; j++) begin
            cnt = 0;
            for (int i = 0; i < N_IN; i++) begin
                xi = int'(f[i*FEAT_W +: FEAT_W]) >= (1 << (FEAT_W-1));
                if (xi == w_ih[j][i]) cnt++;
            end
            h[j] = (cnt + bias[j] - N_IN/2) >= 0;
        end
        ci = 0;
        cs = -1;
        for (int k = 0; k < N_OUT; k++) begin
            sc = 0;
            for (int j = 0; j < N_HID; j++) if (h[j] == w_ho[k][j]) sc++;
            if (sc > cs) begin
                cs = sc;
                ci = k;
            end
        end
    endfunction

    task automatic load_weights();
        logic [WBITS-1:0] v = pack();
        for (int b = WBITS-1; b >= 0; b--) begin
            @(negedge clk);
            w_load = 1'b1;
            w_bit  = v[b];
        end
        @(negedge clk);
        w_load = 1'b0;
        w_bit  = 1'b0;
    endtask

    task automatic run(input string tag, input logic [FW-1:0] f, input bit perturb);
        logic [N_HID-1:0] h;
        int ci, cs, n;
        model(f, h, ci, cs);
        @(negedge clk);
        feat_in = f;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!done && n < 40) begin
            if (n == 5) chk({tag, "_busy"}, busy, 1);
            if (perturb && n == 3) feat_in = FW'($urandom);
            if (perturb && n >= 2 && n <= 10) begin
                start  = 1'($urandom);
                w_load = 1'b1;
                w_bit  = 1'($urandom);
            end else begin
                start  = 1'b0;
                w_load = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start  = 1'b0;
        w_load = 1'b0;
        chk({tag, "_latency"}, n, LAT);
        chk({tag, "_class_idx"}, class_idx, ci);
        chk({tag, "_class_score"}, class_score, cs);
        chk({tag, "_hidden_act"}, hidden_act, h);
        @(negedge clk);
        chk({tag, "_done_pulse"}, {busy, done}, 0);
        chk({tag, "_held_idx"}, class_idx, ci);
    endtask

    initial begin
        logic [FW-1:0] f;
        rst = 1'b1; start = 1'b0; w_load = 1'b0; w_bit = 1'b0; feat_in = '0;
        clear_weights();
        #3;
        chk("reset_outputs", {busy, done, class_idx, class_score, hidden_act}, 0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            w_load = 1'b1;
            w_bit  = 1'b1;
        end
        @(negedge clk);
        w_load = 1'b0;
        w_bit  = 1'b0;
        rst = 1'b0;

        run("zero_weights", '0, 0);

        clear_weights();
        for (int j = 0; j < N_HID; j++) begin
            for (int i = 0; i < N_IN; i++) w_ih[j][i] = 1'b1;
            w_ho[2][j] = 1'b1;
        end
        load_weights();
        run("class2", {FW{1'b1}}, 0);

        clear_weights();
        for (int j = 0; j < N_HID; j++) bias[j] = -8;
        load_weights();
        run("neg_bias", '0, 0);

        random_weights();
        load_weights();
        for (int r = 0; r < 6; r++) run($sformatf("rand%0d", r), FW'($urandom), 0);

        f = FW'($urandom);
        run("perturbed", f, 1);
        run("unperturbed", f, 0);

        @(negedge clk);
        feat_in = FW'($urandom);
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_outputs", {busy, done, class_idx, class_score, hidden_act}, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("abort_no_done%0d", c), done, 0);
        end
        rst = 1'b0;
        clear_weights();
        run("after_abort_zero", FW'($urandom), 0);

        random_weights();
        load_weights();
        for (int r = 0; r < 4; r++) run($sformatf("reload%0d", r), FW'($urandom), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
